sr_fifo_port: RTL and testbench
===============================

Name: sr_fifo_port

Overview:
- CPU-facing responder for the core's 16-bit FIFO push/pop interface. The core drives push, pop and din, and samples dout in the pop cycle.
- Holds two independent queues:
  - Outbound: the CPU pushes words, which drain to an external valid/ready stream.
  - Inbound: the external stream fills the queue, and the CPU pops words from it.
- Sits between sr_cpu and a peripheral or testbench stream. Replaces the simple fifo instance.

Parameters:
- WIDTH, 16, data word width (matches the CPU fifo path).
- DEPTH, 8, entries per queue; power of two, at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- push  in  1  CPU push strobe; one word per cycle.
- din  in  WIDTH  CPU push data.
- pop  in  1  CPU pop strobe; one word per cycle.
- dout  out  WIDTH  inbound head word; combinational, valid in the pop cycle.
- txData  out  WIDTH  outbound head word.
- txValid  out  1  outbound queue not empty.
- txReady  in  1  external sink accepts txData.
- rxData  in  WIDTH  external inbound word.
- rxValid  in  1  rxData valid.
- rxReady  out  1  inbound queue not full.
- outCount  out  CW  outbound occupancy, 0..DEPTH.
- inCount  out  CW  inbound occupancy, 0..DEPTH.
- overflow  out  1  sticky: a CPU push was dropped.
- underflow  out  1  sticky: a CPU pop hit an empty queue.
- clrErr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, any cycle, including mid-transfer):
  - Pointers and counts go to 0.
  - txValid=0, rxReady=1, dout=0, txData=0.
  - overflow=0, underflow=0.
  - Storage contents are not reset but are never visible: dout and txData are forced to 0 while the corresponding queue is empty.
- Each queue is a circular buffer with separate read and write pointers of log2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0. The count register determines full/empty.
- Outbound queue:
  - txHs = txValid & txReady; it pops the head at the clock edge.
  - Push is accepted when outCount<DEPTH, or when outCount==DEPTH and txHs is high in the same cycle.
  - A push that is not accepted drops the word and sets overflow at the next edge. Count is unchanged by the dropped push.
  - Accepted push plus txHs in the same cycle: count is unchanged and both pointers advance.
  - Pushed data is visible on txData no earlier than the next cycle (registered write). There is no fall-through.
  - txValid = (outCount!=0). txData holds steady while txValid=1 and txReady=0.
- Inbound queue:
  - rxReady = (inCount<DEPTH). It depends on registered count only, with no combinational path from pop.
  - rxHs = rxValid & rxReady writes rxData at the edge.
  - dout = head word when inCount!=0, else 0.
  - A pop with inCount!=0 advances the read pointer at the edge.
  - A pop with inCount==0 returns dout=0, sets underflow, and leaves the pointer unchanged.
  - rxHs plus a valid pop in the same cycle: count is unchanged.
  - rxHs plus a pop on an empty queue: the word is stored, underflow is set, and count becomes 1. The popped value is 0; there is no bypass.
- Sticky flags:
  - Set by the events above.
  - Cleared by clrErr at the edge.
  - clrErr and a new error in the same cycle: the set wins (flag=1).
- Counts are registered and reflect the state after the previous edge. Latency: push -> txValid is 1 cycle; rxHs -> dout valid is 1 cycle.
- Combinational outputs (dout, txData, txValid, rxReady) derive only from registered state.

Test Plan:
- Reset then idle -> txValid=0, rxReady=1, outCount=0, inCount=0, dout=0, overflow=underflow=0. Assert rst mid-stream with outCount=3 -> all of these immediately return to the same values.
- txReady=0; CPU pushes 0x0001..0x0008 on consecutive cycles, then pushes 0x0009 -> outCount=8, overflow=1. Raise txReady -> txData sequence 0x0001..0x0008, with 0x0009 absent, then txValid=0.
- Outbound full (8) with txReady=1 and push 0xBEEF in the same cycle -> push accepted, overflow stays 0, outCount stays 8. 0xBEEF emerges as the 8th word after the drain.
- rxValid=1 with rxData=0xA5A5 then 0x5A5A -> inCount=2, dout=0xA5A5. Pop -> dout=0x5A5A next cycle. Pop again -> inCount=0, dout=0. A third pop -> underflow=1, dout=0.
- Fill inbound to 8 -> rxReady=0, and a held rxValid word is not taken. Pop once -> rxReady=1 next cycle and the held word is accepted. Run 20 words through with random pop/rxValid gaps -> order preserved across pointer wrap.
- underflow=1, then clrErr=1 together with a pop on empty -> underflow stays 1. clrErr alone on the next cycle -> underflow=0.

Source files
------------

// File: rtl/sr_fifo_port.sv
// CPU-facing FIFO port: an outbound queue the CPU pushes into and a valid/ready stream drains,
// plus an inbound queue a valid/ready stream fills and the CPU pops from.
module sr_fifo_port #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] txData,
    output logic             txValid,
    input  logic             txReady,
    input  logic [WIDTH-1:0] rxData,
    input  logic             rxValid,
    output logic             rxReady,
    output logic [CW-1:0]    outCount,
    output logic [CW-1:0]    inCount,
    output logic             overflow,
    output logic             underflow,
    input  logic             clrErr
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] outMem_q [DEPTH];
    logic [WIDTH-1:0] inMem_q  [DEPTH];
    logic [PW-1:0]    outWr_q, outRd_q, inWr_q, inRd_q;
    logic [CW-1:0]    outCount_q, outCount_d, inCount_q, inCount_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             txHs, pushOk, rxHs, popOk, popEmpty;

    assign txValid  = (outCount_q != '0);
    assign rxReady  = (outCount_q == outCount_q) && (inCount_q < CW'(DEPTH));
    assign txData   = txValid ? outMem_q[outRd_q] : '0;
    assign dout     = (inCount_q != '0) ? inMem_q[inRd_q] : '0;
    assign outCount = outCount_q;
    assign inCount  = inCount_q;
    assign overflow = overflow_q;
    assign underflow = underflow_q;

    // A full outbound queue still takes a push when the head leaves in the same cycle.
    assign txHs     = txValid & txReady;
    assign pushOk   = push & ((outCount_q < CW'(DEPTH)) | txHs);
    assign rxHs     = rxValid & rxReady;
    assign popOk    = pop & (inCount_q != '0);
    assign popEmpty = pop & (inCount_q == '0);

    always_comb begin
        outCount_d = outCount_q;
        if (pushOk && !txHs)
            outCount_d = outCount_q + CW'(1);
        else if (!pushOk && txHs)
            outCount_d = outCount_q - CW'(1);

        inCount_d = inCount_q;
        if (rxHs && !popOk)
            inCount_d = inCount_q + CW'(1);
        else if (!rxHs && popOk)
            inCount_d = inCount_q - CW'(1);

        // A new error in the same cycle as clrErr keeps the flag set.
        overflow_d  = (push && !pushOk) ? 1'b1 : (clrErr ? 1'b0 : overflow_q);
        underflow_d = popEmpty ? 1'b1 : (clrErr ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outWr_q     <= '0;
            outRd_q     <= '0;
            inWr_q      <= '0;
            inRd_q      <= '0;
            outCount_q  <= '0;
            inCount_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (pushOk) outWr_q <= outWr_q + PW'(1);
            if (txHs)   outRd_q <= outRd_q + PW'(1);
            if (rxHs)   inWr_q  <= inWr_q + PW'(1);
            if (popOk)  inRd_q  <= inRd_q + PW'(1);
            outCount_q  <= outCount_d;
            inCount_q   <= inCount_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; empty queues mask it on dout/txData.
    always_ff @(posedge clk) begin
        if (pushOk) outMem_q[outWr_q] <= din;
        if (rxHs)   inMem_q[inWr_q]   <= rxData;
    end

endmodule

// File: tb/tb_sr_fifo_port.sv
// Self-checking bench for sr_fifo_port: directed vector table plus a queue scoreboard
// that predicts every word leaving either queue.
module tb_sr_fifo_port;
    logic        clk, rst;
    logic        push, pop, txReady, rxValid, clrErr;
    logic [15:0] din, rxData, dout, txData;
    logic        txValid, rxReady, overflow, underflow;
    logic [3:0]  outCount, inCount;

    sr_fifo_port #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .outCount(outCount), .inCount(inCount),
        .overflow(overflow), .underflow(underflow), .clrErr(clrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic push; logic [15:0] din; logic pop; logic txReady;
        logic rxValid; logic [15:0] rxData; logic clrErr;
        int eOut; int eIn; logic eTxValid; logic eRxReady;
        logic eOvf; logic eUnf; logic [15:0] eDout; logic [15:0] eTxData;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] outQ[$];
    logic [15:0] inQ[$];
    logic        mOvf, mUnf;
    int          total, passed;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive inputs, compare against the scoreboard, advance the model, clock.
    task automatic applyStimulus(input logic p, input logic [15:0] d, input logic po,
                                 input logic tr, input logic rv, input logic [15:0] rd,
                                 input logic ce);
        int mOut, mIn;
        logic txHs, pushOk, popOk;
        logic [15:0] exp;
        push = p; din = d; pop = po; txReady = tr; rxValid = rv; rxData = rd; clrErr = ce;
        #1;
        mOut = outQ.size();
        mIn  = inQ.size();
        checkOutput("sb.outCount", 32'(outCount), 32'(mOut));
        checkOutput("sb.inCount", 32'(inCount), 32'(mIn));
        checkOutput("sb.txValid", 32'(txValid), 32'(mOut != 0));
        checkOutput("sb.rxReady", 32'(rxReady), 32'(mIn < 8));
        checkOutput("sb.overflow", 32'(overflow), 32'(mOvf));
        checkOutput("sb.underflow", 32'(underflow), 32'(mUnf));
        txHs   = (mOut != 0) && tr;
        pushOk = p && ((mOut < 8) || txHs);
        popOk  = po && (mIn != 0);
        if (txHs) begin
            exp = outQ.pop_front();
            checkOutput("sb.txData", 32'(txData), 32'(exp));
        end
        if (popOk) begin
            exp = inQ.pop_front();
            checkOutput("sb.dout", 32'(dout), 32'(exp));
        end else if (po) begin
            checkOutput("sb.doutEmpty", 32'(dout), 32'h0);
        end
        if (pushOk) outQ.push_back(d);
        if (rv && (mIn < 8)) inQ.push_back(rd);
        mOvf = (p && !pushOk) ? 1'b1 : (ce ? 1'b0 : mOvf);
        mUnf = (po && mIn == 0) ? 1'b1 : (ce ? 1'b0 : mUnf);
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic p, input logic [15:0] d, input logic po,
                                   input logic tr, input logic rv, input logic [15:0] rd,
                                   input logic ce, input int eo, input int ei,
                                   input logic etv, input logic err, input logic eov,
                                   input logic eun, input logic [15:0] edo, input logic [15:0] etx);
        vec_t v;
        v.push = p; v.din = d; v.pop = po; v.txReady = tr; v.rxValid = rv; v.rxData = rd;
        v.clrErr = ce; v.eOut = eo; v.eIn = ei; v.eTxValid = etv; v.eRxReady = err;
        v.eOvf = eov; v.eUnf = eun; v.eDout = edo; v.eTxData = etx;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0; passed = 0; mOvf = 0; mUnf = 0;
        push = 0; din = 0; pop = 0; txReady = 0; rxValid = 0; rxData = 0; clrErr = 0;

        // Expected state after each vector's clock edge.
        addVec(0,0,0,0,0,0,0, 0,0,0,1,0,0, 16'h0,16'h0);
        for (int i = 1; i <= 8; i++)
            addVec(1,16'(i),0,0,0,0,0, i,0,1,1,0,0, 16'h0,16'h1);
        addVec(1,16'h9,0,0,0,0,0, 8,0,1,1,1,0, 16'h0,16'h1);
        for (int k = 1; k <= 8; k++)
            addVec(0,0,0,1,0,0,0, 8-k,0,(k<8),1,1,0, 16'h0,(k<8)?16'(k+1):16'h0);
        addVec(0,0,0,0,0,0,1, 0,0,0,1,0,0, 16'h0,16'h0);
        for (int i = 0; i < 8; i++)
            addVec(1,16'(16'h10+i),0,0,0,0,0, i+1,0,1,1,0,0, 16'h0,16'h10);
        addVec(1,16'hBEEF,0,1,0,0,0, 8,0,1,1,0,0, 16'h0,16'h11);
        for (int k = 1; k <= 8; k++)
            addVec(0,0,0,1,0,0,0, 8-k,0,(k<8),1,0,0, 16'h0,
                   (k<7) ? 16'(16'h11+k) : ((k==7) ? 16'hBEEF : 16'h0));
        addVec(0,0,0,0,1,16'hA5A5,0, 0,1,0,1,0,0, 16'hA5A5,16'h0);
        addVec(0,0,0,0,1,16'h5A5A,0, 0,2,0,1,0,0, 16'hA5A5,16'h0);
        addVec(0,0,1,0,0,0,0, 0,1,0,1,0,0, 16'h5A5A,16'h0);
        addVec(0,0,1,0,0,0,0, 0,0,0,1,0,0, 16'h0,16'h0);
        addVec(0,0,1,0,0,0,0, 0,0,0,1,0,1, 16'h0,16'h0);
        addVec(0,0,1,0,0,0,1, 0,0,0,1,0,1, 16'h0,16'h0);
        addVec(0,0,0,0,0,0,1, 0,0,0,1,0,0, 16'h0,16'h0);
        for (int i = 0; i < 8; i++)
            addVec(0,0,0,0,1,16'(16'h100+i),0, 0,i+1,0,(i<7),0,0, 16'h100,16'h0);
        addVec(0,0,0,0,1,16'h108,0, 0,8,0,0,0,0, 16'h100,16'h0);
        addVec(0,0,1,0,1,16'h108,0, 0,7,0,1,0,0, 16'h101,16'h0);
        addVec(0,0,0,0,1,16'h108,0, 0,8,0,0,0,0, 16'h101,16'h0);
        for (int k = 1; k <= 8; k++)
            addVec(0,0,1,0,0,0,0, 0,8-k,0,1,0,0, (k<8)?16'(16'h101+k):16'h0,16'h0);
        addVec(0,0,1,0,1,16'h77,0, 0,1,0,1,0,1, 16'h77,16'h0);
        addVec(0,0,1,0,0,0,0, 0,0,0,1,0,1, 16'h0,16'h0);
        addVec(0,0,0,0,0,0,1, 0,0,0,1,0,0, 16'h0,16'h0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset.txValid", 32'(txValid), 32'h0);
        checkOutput("reset.rxReady", 32'(rxReady), 32'h1);
        checkOutput("reset.dout", 32'(dout), 32'h0);
        checkOutput("reset.txData", 32'(txData), 32'h0);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].push, vecs[n].din, vecs[n].pop, vecs[n].txReady,
                          vecs[n].rxValid, vecs[n].rxData, vecs[n].clrErr);
            checkOutput($sformatf("vec%0d.outCount", n), 32'(outCount), 32'(vecs[n].eOut));
            checkOutput($sformatf("vec%0d.inCount", n), 32'(inCount), 32'(vecs[n].eIn));
            checkOutput($sformatf("vec%0d.txValid", n), 32'(txValid), 32'(vecs[n].eTxValid));
            checkOutput($sformatf("vec%0d.rxReady", n), 32'(rxReady), 32'(vecs[n].eRxReady));
            checkOutput($sformatf("vec%0d.overflow", n), 32'(overflow), 32'(vecs[n].eOvf));
            checkOutput($sformatf("vec%0d.underflow", n), 32'(underflow), 32'(vecs[n].eUnf));
            checkOutput($sformatf("vec%0d.dout", n), 32'(dout), 32'(vecs[n].eDout));
            checkOutput($sformatf("vec%0d.txData", n), 32'(txData), 32'(vecs[n].eTxData));
        end

        // Asynchronous reset in the middle of a cycle with both queues occupied.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 16'(16'h30+i), 0, 0, 1, 16'(16'h40+i), 0);
        push = 0; pop = 0; txReady = 0; rxValid = 0; clrErr = 0;
        checkOutput("mid.outCountBefore", 32'(outCount), 32'h3);
        checkOutput("mid.inCountBefore", 32'(inCount), 32'h3);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid.txValid", 32'(txValid), 32'h0);
        checkOutput("mid.rxReady", 32'(rxReady), 32'h1);
        checkOutput("mid.outCount", 32'(outCount), 32'h0);
        checkOutput("mid.inCount", 32'(inCount), 32'h0);
        checkOutput("mid.dout", 32'(dout), 32'h0);
        checkOutput("mid.txData", 32'(txData), 32'h0);
        checkOutput("mid.overflow", 32'(overflow), 32'h0);
        checkOutput("mid.underflow", 32'(underflow), 32'h0);
        outQ.delete(); inQ.delete(); mOvf = 0; mUnf = 0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic on both queues; at least 20 inbound words must come out in order.
        begin
            int sent, popped, cyc;
            logic rv, po;
            sent = 0; popped = 0; cyc = 0;
            while (popped < 20 && cyc < 2000) begin
                rv = (sent < 24) && ($urandom_range(0, 1) == 1);
                po = ($urandom_range(0, 2) == 0);
                if (po && inQ.size() != 0) popped++;
                if (rv && inQ.size() < 8) sent++;
                applyStimulus($urandom_range(0, 1) == 1, 16'($urandom), po,
                              $urandom_range(0, 1) == 1, rv, 16'(16'h200 + sent), 0);
                cyc++;
            end
            checkOutput("rand.wordsPopped", 32'(popped >= 20), 32'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
